// File: rtl/soft_error_monitor.sv
// Soft-error monitor: counts corruption, unknown-TTC and DDR3-overflow events
// and promotes each to a sticky hard error once its count reaches a
// programmable threshold. A single comparator is shared via a 3-slot scan.
module soft_error_monitor #(
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned DDR3_WARN_MIN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 monitor_en,
    input  logic                 clear,
    input  logic                 ev_data_corrupt,
    input  logic                 ev_unknown_ttc,
    input  logic                 ev_ddr3_overflow,
    input  logic [CNT_WIDTH-1:0] thres_data_corrupt,
    input  logic [CNT_WIDTH-1:0] thres_unknown_ttc,
    input  logic [CNT_WIDTH-1:0] thres_ddr3_overflow,
    output logic [CNT_WIDTH-1:0] cs_mismatch_count,
    output logic [CNT_WIDTH-1:0] unknown_cmd_count,
    output logic [CNT_WIDTH-1:0] ddr3_overflow_count,
    output logic                 error_data_corrupt,
    output logic                 error_unknown_ttc,
    output logic                 error_ddr3_overflow,
    output logic                 ddr3_overflow_warning,
    output logic [1:0]           scan_sel
);

    typedef enum logic [1:0] {
        S_CORRUPT = 2'd0,
        S_TTC     = 2'd1,
        S_DDR3    = 2'd2
    } scan_t;

    localparam logic [CNT_WIDTH-1:0] WARN_MIN = CNT_WIDTH'(DDR3_WARN_MIN);

    scan_t                state;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [CNT_WIDTH-1:0] sel_thr;
    logic                 hit;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                     input logic ev);
        return (ev && (c != '1)) ? c + CNT_WIDTH'(1) : c;
    endfunction

    // Round-robin scan slot; not affected by clear, illegal codes recover to S_CORRUPT
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_CORRUPT;
        end else begin
            case (state)
                S_CORRUPT: state <= S_TTC;
                S_TTC:     state <= S_DDR3;
                S_DDR3:    state <= S_CORRUPT;
                default:   state <= S_CORRUPT;
            endcase
        end
    end

    assign scan_sel = state;

    // Route the scanned source's count and live threshold into the shared comparator
    always_comb begin
        sel_cnt = '0;
        sel_thr = '0;
        case (state)
            S_CORRUPT: begin
                sel_cnt = cs_mismatch_count;
                sel_thr = thres_data_corrupt;
            end
            S_TTC: begin
                sel_cnt = unknown_cmd_count;
                sel_thr = thres_unknown_ttc;
            end
            S_DDR3: begin
                sel_cnt = ddr3_overflow_count;
                sel_thr = thres_ddr3_overflow;
            end
            default: begin
                sel_cnt = '0;
                sel_thr = '0;
            end
        endcase
        hit = monitor_en && (sel_thr != '0) && (sel_cnt >= sel_thr);
    end

    // Saturating event counters; clear drops any coincident event
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cs_mismatch_count   <= '0;
            unknown_cmd_count   <= '0;
            ddr3_overflow_count <= '0;
        end else begin
            cs_mismatch_count   <= sat_inc(cs_mismatch_count, ev_data_corrupt);
            unknown_cmd_count   <= sat_inc(unknown_cmd_count, ev_unknown_ttc);
            ddr3_overflow_count <= sat_inc(ddr3_overflow_count, ev_ddr3_overflow);
        end
    end

    // Sticky hard-error flags, set only for the source in the current scan slot
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            error_data_corrupt  <= 1'b0;
            error_unknown_ttc   <= 1'b0;
            error_ddr3_overflow <= 1'b0;
        end else if (hit) begin
            case (state)
                S_CORRUPT: error_data_corrupt  <= 1'b1;
                S_TTC:     error_unknown_ttc   <= 1'b1;
                S_DDR3:    error_ddr3_overflow <= 1'b1;
                default:   ;
            endcase
        end
    end

    // DDR3 warning tracks the registered count with one cycle of lag
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ddr3_overflow_warning <= 1'b0;
        end else begin
            ddr3_overflow_warning <= (ddr3_overflow_count >= WARN_MIN);
        end
    end

endmodule

// File: tb/tb_soft_error_monitor.sv
// Self-checking bench for soft_error_monitor: directed scenarios plus a
// randomized run, all checked against a cycle-level behavioural model.
module tb_soft_error_monitor;

    localparam int W = 32;
    localparam longint unsigned MAXC = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, monitor_en, clear;
    logic         ev_dc, ev_ut, ev_dd;
    logic [W-1:0] thr_dc, thr_ut, thr_dd;
    logic [W-1:0] cnt_dc, cnt_ut, cnt_dd;
    logic         err_dc, err_ut, err_dd, warn;
    logic [1:0]   scan_sel;

    // Narrow instance for saturation behaviour
    logic         s_reset, s_en, s_clear, s_ev_dc, s_ev_ut, s_ev_dd;
    logic [3:0]   s_thr_dc, s_thr_ut, s_thr_dd;
    logic [3:0]   s_cnt_dc, s_cnt_ut, s_cnt_dd;
    logic         s_err_dc, s_err_ut, s_err_dd, s_warn;
    logic [1:0]   s_scan;

    soft_error_monitor #(.CNT_WIDTH(W), .DDR3_WARN_MIN(1)) dut (
        .clk(clk), .reset(reset), .monitor_en(monitor_en), .clear(clear),
        .ev_data_corrupt(ev_dc), .ev_unknown_ttc(ev_ut), .ev_ddr3_overflow(ev_dd),
        .thres_data_corrupt(thr_dc), .thres_unknown_ttc(thr_ut), .thres_ddr3_overflow(thr_dd),
        .cs_mismatch_count(cnt_dc), .unknown_cmd_count(cnt_ut), .ddr3_overflow_count(cnt_dd),
        .error_data_corrupt(err_dc), .error_unknown_ttc(err_ut), .error_ddr3_overflow(err_dd),
        .ddr3_overflow_warning(warn), .scan_sel(scan_sel)
    );

    soft_error_monitor #(.CNT_WIDTH(4), .DDR3_WARN_MIN(1)) dut_small (
        .clk(clk), .reset(s_reset), .monitor_en(s_en), .clear(s_clear),
        .ev_data_corrupt(s_ev_dc), .ev_unknown_ttc(s_ev_ut), .ev_ddr3_overflow(s_ev_dd),
        .thres_data_corrupt(s_thr_dc), .thres_unknown_ttc(s_thr_ut), .thres_ddr3_overflow(s_thr_dd),
        .cs_mismatch_count(s_cnt_dc), .unknown_cmd_count(s_cnt_ut), .ddr3_overflow_count(s_cnt_dd),
        .error_data_corrupt(s_err_dc), .error_unknown_ttc(s_err_ut), .error_ddr3_overflow(s_err_dd),
        .ddr3_overflow_warning(s_warn), .scan_sel(s_scan)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: event tallies, sticky flags, warning, and which source
    // the scan is looking at (cycles since reset, modulo 3)
    longint unsigned m_cnt[3];
    bit              m_err[3];
    bit              m_warn;
    int              m_slot;

    logic [95:0] exp_cnt;
    logic [3:0]  exp_flg;

    function automatic logic [95:0] model_counts();
        return {m_cnt[0][31:0], m_cnt[1][31:0], m_cnt[2][31:0]};
    endfunction

    function automatic logic [3:0] model_flags();
        return {m_err[0], m_err[1], m_err[2], m_warn};
    endfunction

    // Apply one clock edge to both DUT and model, then release pulse inputs
    task automatic step();
        longint unsigned thr[3];
        bit ev[3];
        thr[0] = thr_dc; thr[1] = thr_ut; thr[2] = thr_dd;
        ev[0] = ev_dc;   ev[1] = ev_ut;   ev[2] = ev_dd;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_err[i] = 0; end
            m_warn = 0;
            m_slot = 0;
        end else begin
            if (!clear && monitor_en && thr[m_slot] != 0 && m_cnt[m_slot] >= thr[m_slot])
                m_err[m_slot] = 1;
            m_warn = !clear && (m_cnt[2] >= 1);
            for (int i = 0; i < 3; i++) begin
                if (clear) begin
                    m_cnt[i] = 0;
                    m_err[i] = 0;
                end else if (ev[i] && m_cnt[i] < MAXC) begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            m_slot = (m_slot + 1) % 3;
        end
        @(posedge clk);
        #1;
        ev_dc = 0; ev_ut = 0; ev_dd = 0; clear = 0;
        s_ev_dc = 0; s_clear = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        step();
        total++;
        if ({cnt_dc, cnt_ut, cnt_dd} !== 96'd0) begin
            $display("FAIL reset_counts actual=%h required=0", {cnt_dc, cnt_ut, cnt_dd});
        end else passed++;
        total++;
        if ({err_dc, err_ut, err_dd, warn} !== 4'b0000) begin
            $display("FAIL reset_flags actual=%b required=0000", {err_dc, err_ut, err_dd, warn});
        end else passed++;
        total++;
        if (scan_sel !== 2'd0) begin
            $display("FAIL reset_scan actual=%0d required=0", scan_sel);
        end else passed++;
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (scan_sel !== 2'(m_slot)) begin
                $display("FAIL scan_rotate actual=%0d required=%0d", scan_sel, m_slot);
            end else passed++;
        end
    endtask

    task automatic test_threshold_trip();
        monitor_en = 1; thr_dc = 3; thr_ut = 0; thr_dd = 0;
        clear = 1;
        step();
        for (int k = 0; k < 3; k++) begin
            ev_dc = 1;
            step();
        end
        total++;
        if (cnt_dc !== 32'd3) begin
            $display("FAIL trip_count actual=%0d required=3", cnt_dc);
        end else passed++;
        for (int k = 0; k < 3; k++) begin
            step();
            exp_flg = model_flags();
            total++;
            if ({err_dc, err_ut, err_dd, warn} !== exp_flg) begin
                $display("FAIL trip_flags actual=%b required=%b", {err_dc, err_ut, err_dd, warn}, exp_flg);
            end else passed++;
        end
        total++;
        if ({err_dc, err_ut, err_dd} !== 3'b100) begin
            $display("FAIL trip_latency actual=%b required=100", {err_dc, err_ut, err_dd});
        end else passed++;
    endtask

    task automatic test_disabled_threshold();
        thr_ut = 0;
        clear = 1;
        step();
        for (int k = 0; k < 100; k++) begin
            ev_ut = 1;
            step();
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (3) step();
        total++;
        if (cnt_ut !== 32'd100) begin
            $display("FAIL disabled_count actual=%0d required=100", cnt_ut);
        end else passed++;
        total++;
        if (err_ut !== 1'b0) begin
            $display("FAIL disabled_flag actual=%b required=0", err_ut);
        end else passed++;
    endtask

    task automatic test_monitor_enable();
        monitor_en = 0; thr_dc = 4; thr_ut = 4; thr_dd = 4;
        clear = 1;
        step();
        for (int k = 0; k < 10; k++) begin
            ev_dc = 1; ev_ut = 1; ev_dd = 1;
            step();
        end
        repeat (4) step();
        total++;
        if ({cnt_dc, cnt_ut, cnt_dd} !== {32'd10, 32'd10, 32'd10}) begin
            $display("FAIL gated_counts actual=%h required=10 each", {cnt_dc, cnt_ut, cnt_dd});
        end else passed++;
        total++;
        if ({err_dc, err_ut, err_dd} !== 3'b000) begin
            $display("FAIL gated_flags actual=%b required=000", {err_dc, err_ut, err_dd});
        end else passed++;
        monitor_en = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            exp_flg = model_flags();
            total++;
            if ({err_dc, err_ut, err_dd, warn} !== exp_flg) begin
                $display("FAIL enable_order actual=%b required=%b", {err_dc, err_ut, err_dd, warn}, exp_flg);
            end else passed++;
        end
        total++;
        if ({err_dc, err_ut, err_dd} !== 3'b111) begin
            $display("FAIL enable_all actual=%b required=111", {err_dc, err_ut, err_dd});
        end else passed++;
    endtask

    task automatic test_raise_threshold();
        thr_dd = 1000;
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (err_dd !== 1'b1) begin
                $display("FAIL raise_sticky actual=%b required=1", err_dd);
            end else passed++;
        end
        clear = 1;
        step();
        total++;
        if ({err_dd, cnt_dd} !== {1'b0, 32'd0}) begin
            $display("FAIL raise_clear actual=%b/%0d required=0/0", err_dd, cnt_dd);
        end else passed++;
    endtask

    task automatic test_clear_collision();
        monitor_en = 1; thr_dd = 3;
        clear = 1;
        step();
        for (int k = 0; k < 5; k++) begin
            ev_dd = 1;
            step();
        end
        repeat (4) step();
        total++;
        if ({cnt_dd, err_dd, warn} !== {32'd5, 1'b1, 1'b1}) begin
            $display("FAIL collide_pre actual=%0d/%b/%b required=5/1/1", cnt_dd, err_dd, warn);
        end else passed++;
        ev_dd = 1;
        clear = 1;
        step();
        total++;
        if ({cnt_dd, err_dd, warn} !== {32'd0, 1'b0, 1'b0}) begin
            $display("FAIL collide_post actual=%0d/%b/%b required=0/0/0", cnt_dd, err_dd, warn);
        end else passed++;
    endtask

    task automatic test_saturation();
        longint unsigned expv;
        s_reset = 1;
        step();
        s_reset = 0; s_en = 1; s_thr_dc = 4'd15;
        for (int i = 1; i <= 18; i++) begin
            s_ev_dc = 1;
            step();
            expv = (i > 15) ? 15 : i;
            total++;
            if (s_cnt_dc !== 4'(expv)) begin
                $display("FAIL saturate_count actual=%0d required=%0d", s_cnt_dc, expv);
            end else passed++;
        end
        repeat (3) step();
        total++;
        if (s_err_dc !== 1'b1) begin
            $display("FAIL saturate_flag actual=%b required=1", s_err_dc);
        end else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ev_dc = ($urandom_range(0, 3) == 0);
            ev_ut = ($urandom_range(0, 3) == 0);
            ev_dd = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0) monitor_en = ~monitor_en;
            if ($urandom_range(0, 24) == 0) begin
                thr_dc = $urandom_range(0, 25);
                thr_ut = $urandom_range(0, 25);
                thr_dd = $urandom_range(0, 25);
            end
            step();
            exp_cnt = model_counts();
            exp_flg = model_flags();
            total++;
            if ({cnt_dc, cnt_ut, cnt_dd} !== exp_cnt) begin
                $display("FAIL random_counts cycle=%0d actual=%h required=%h", c, {cnt_dc, cnt_ut, cnt_dd}, exp_cnt);
            end else passed++;
            total++;
            if ({err_dc, err_ut, err_dd, warn} !== exp_flg) begin
                $display("FAIL random_flags cycle=%0d actual=%b required=%b", c, {err_dc, err_ut, err_dd, warn}, exp_flg);
            end else passed++;
        end
    endtask

    task automatic test_reset_midop();
        ev_dc = 1; ev_ut = 1; ev_dd = 1;
        step();
        reset = 1;
        ev_dc = 1; ev_ut = 1; ev_dd = 1;
        step();
        reset = 0;
        total++;
        if ({cnt_dc, cnt_ut, cnt_dd, err_dc, err_ut, err_dd, warn, scan_sel} !== 102'd0) begin
            $display("FAIL midop_reset actual=%h/%b/%0d required=0", {cnt_dc, cnt_ut, cnt_dd},
                     {err_dc, err_ut, err_dd, warn}, scan_sel);
        end else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; monitor_en = 0; clear = 0;
        ev_dc = 0; ev_ut = 0; ev_dd = 0;
        thr_dc = '0; thr_ut = '0; thr_dd = '0;
        s_reset = 1; s_en = 0; s_clear = 0;
        s_ev_dc = 0; s_ev_ut = 0; s_ev_dd = 0;
        s_thr_dc = '0; s_thr_ut = '0; s_thr_dd = '0;
        for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_err[i] = 0; end
        m_warn = 0;
        m_slot = 0;

        test_reset();
        test_threshold_trip();
        test_disabled_threshold();
        test_monitor_enable();
        test_raise_threshold();
        test_clear_collision();
        test_saturation();
        test_random();
        test_reset_midop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
